// File: rtl/offset_gain_corr_pkg.sv
// rtl/offset_gain_corr_pkg.sv - calibration FSM encoding and unity-gain helper for offset_gain_corr
package offset_gain_corr_pkg;

  typedef enum logic [1:0] {
    UNCAL    = 2'd0,
    CAL_WAIT = 2'd1,
    ACTIVE   = 2'd2
  } cal_state_t;

  function automatic int unsigned unity_gain(input int unsigned gf);
    return 32'd1 << gf;
  endfunction

endpackage

// File: rtl/offset_gain_corr_sat_clip.sv
// rtl/offset_gain_corr_sat_clip.sv - module sat_clip: signed saturation from IW to OW bits with clip flag
module sat_clip #(
  parameter int IW = 25,
  parameter int OW = 24
) (
  input  logic signed [IW-1:0] din,
  output logic signed [OW-1:0] dout,
  output logic                 clip
);

  localparam logic signed [OW-1:0] MAX_V = {1'b0, {(OW-1){1'b1}}};
  localparam logic signed [OW-1:0] MIN_V = {1'b1, {(OW-1){1'b0}}};

  // Value fits when every bit from the output sign position upward matches.
  logic [IW-OW:0] top_bits;
  assign top_bits = din[IW-1:OW-1];

  always_comb begin
    clip = !((&top_bits) || !(|top_bits));
    dout = din[OW-1:0];
    if (clip) begin
      dout = din[IW-1] ? MIN_V : MAX_V;
    end
  end

endmodule

// File: rtl/offset_gain_corr.sv
// rtl/offset_gain_corr.sv - offset/gain correction pipeline with calibration FSM and saturation count
// Optional gain stage enabled by macro OFFSET_GAIN_CORR_GAIN_EN (latency 3, else latency 2 with unity gain).
module offset_gain_corr
  import offset_gain_corr_pkg::*;
#(
  parameter int W   = 24,
  parameter int GF  = 14,
  parameter int SCW = 16
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           cal_start,
  input  logic [W-1:0]   offset_in,
  input  logic           offset_load,
  input  logic [GF+1:0]  gain_in,
  input  logic           gain_load,
  input  logic [W-1:0]   din,
  input  logic           din_valid,
  output logic [W-1:0]   dout,
  output logic           dout_valid,
  output logic           sat_flag,
  output logic [SCW-1:0] sat_count,
  input  logic           sat_clr,
  output logic           calibrated
);

  cal_state_t state_q;
  logic signed [W-1:0] offset_q;
  logic                s1_valid;
  logic signed [W:0]   s1_diff;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= UNCAL;
      calibrated <= 1'b0;
    end else begin
      case (state_q)
        UNCAL: begin
          if (offset_load) begin
            state_q    <= ACTIVE;
            calibrated <= 1'b1;
          end else if (cal_start) begin
            state_q    <= CAL_WAIT;
          end
        end
        CAL_WAIT: begin
          if (offset_load) begin
            state_q    <= ACTIVE;
            calibrated <= 1'b1;
          end
        end
        ACTIVE: begin
          // offset_load wins over a simultaneous cal_start
          if (!offset_load && cal_start) begin
            state_q    <= CAL_WAIT;
            calibrated <= 1'b0;
          end
        end
        default: begin
          state_q    <= UNCAL;
          calibrated <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      offset_q <= '0;
      s1_valid <= 1'b0;
      s1_diff  <= '0;
    end else begin
      if (offset_load) offset_q <= offset_in;
      s1_valid <= din_valid && (state_q != CAL_WAIT);
      if (din_valid) s1_diff <= {din[W-1], din} - {offset_q[W-1], offset_q};
    end
  end

`ifdef OFFSET_GAIN_CORR_GAIN_EN
  localparam int CW = W + 4;
  localparam int PW = W + GF + 4;
  localparam logic signed [PW-1:0] RND = PW'(1) << (GF - 1);

  logic        [GF+1:0] gain_q;
  logic        [GF+1:0] s1_gain;
  logic signed [PW-1:0] mul_a;
  logic signed [PW-1:0] mul_b;
  logic signed [PW-1:0] rounded;
  logic signed [CW-1:0] s2_next;
  logic        [GF-1:0] frac_unused;
  logic                 s2_valid;
  logic signed [CW-1:0] s2_val;

  assign mul_a   = s1_diff;
  assign mul_b   = {1'b0, s1_gain};
  assign rounded = mul_a * mul_b + RND;
  assign {s2_next, frac_unused} = rounded;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gain_q   <= (GF+2)'(unity_gain(GF));
      s1_gain  <= (GF+2)'(unity_gain(GF));
      s2_valid <= 1'b0;
      s2_val   <= '0;
    end else begin
      if (gain_load) gain_q <= gain_in;
      // gain travels with its sample so a load never retimes an in-flight value
      if (din_valid) s1_gain <= gain_q;
      s2_valid <= s1_valid;
      if (s1_valid) s2_val <= s2_next;
    end
  end

  logic signed [CW-1:0] clip_in;
  logic                 clip_valid;
  assign clip_in    = s2_val;
  assign clip_valid = s2_valid;
`else
  localparam int CW = W + 1;

  logic unused_gain;
  assign unused_gain = ^{gain_in, gain_load};

  logic signed [CW-1:0] clip_in;
  logic                 clip_valid;
  assign clip_in    = s1_diff;
  assign clip_valid = s1_valid;
`endif

  logic signed [W-1:0] clip_out;
  logic                clip_hit;

  sat_clip #(
    .IW(CW),
    .OW(W)
  ) u_sat_clip (
    .din  (clip_in),
    .dout (clip_out),
    .clip (clip_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dout       <= '0;
      dout_valid <= 1'b0;
      sat_flag   <= 1'b0;
      sat_count  <= '0;
    end else begin
      dout_valid <= clip_valid;
      sat_flag   <= clip_valid && clip_hit;
      if (clip_valid) dout <= clip_out;
      if (sat_clr) begin
        sat_count <= (clip_valid && clip_hit) ? SCW'(1) : '0;
      end else if (clip_valid && clip_hit && !(&sat_count)) begin
        sat_count <= sat_count + SCW'(1);
      end
    end
  end

endmodule

// File: tb/tb_offset_gain_corr.sv
// tb/tb_offset_gain_corr.sv - directed self-checking bench for offset_gain_corr (W=24, GF=14)
module tb_offset_gain_corr;

`ifdef OFFSET_GAIN_CORR_GAIN_EN
  localparam bit GAIN_EN = 1'b1;
  localparam int LAT     = 3;
`else
  localparam bit GAIN_EN = 1'b0;
  localparam int LAT     = 2;
`endif

  logic               clk = 1'b0;
  logic               rst_n;
  logic               cal_start;
  logic signed [23:0] offset_in;
  logic               offset_load;
  logic        [15:0] gain_in;
  logic               gain_load;
  logic signed [23:0] din;
  logic               din_valid;
  logic signed [23:0] dout;
  logic               dout_valid;
  logic               sat_flag;
  logic        [15:0] sat_count;
  logic               sat_clr;
  logic               calibrated;

  int total = 0;
  int bad   = 0;
  logic signed [23:0] exp_d;

  always #5 clk = ~clk;

  offset_gain_corr #(.W(24), .GF(14), .SCW(16)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .cal_start   (cal_start),
    .offset_in   (offset_in),
    .offset_load (offset_load),
    .gain_in     (gain_in),
    .gain_load   (gain_load),
    .din         (din),
    .din_valid   (din_valid),
    .dout        (dout),
    .dout_valid  (dout_valid),
    .sat_flag    (sat_flag),
    .sat_count   (sat_count),
    .sat_clr     (sat_clr),
    .calibrated  (calibrated)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample(input logic signed [23:0] d);
    din       = d;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (LAT - 1) tick();
  endtask

  task automatic load_offset(input logic signed [23:0] o);
    offset_in   = o;
    offset_load = 1'b1;
    tick();
    offset_load = 1'b0;
  endtask

  task automatic load_gain(input logic [15:0] g);
    gain_in   = g;
    gain_load = 1'b1;
    tick();
    gain_load = 1'b0;
  endtask

  task automatic test_reset();
    total++;
    if ({dout, dout_valid, sat_flag, sat_count, calibrated} !== '0) begin
      bad++;
      $display("FAIL reset_state: dout=%0d v=%0b sf=%0b cnt=%0d cal=%0b want all 0",
               dout, dout_valid, sat_flag, sat_count, calibrated);
    end
    sample(24'sd100);
    total++;
    if (dout_valid !== 1'b1 || dout !== 24'sd100 || calibrated !== 1'b0) begin
      bad++;
      $display("FAIL passthru_uncal: v=%0b dout=%0d cal=%0b want 1/100/0", dout_valid, dout, calibrated);
    end
  endtask

  task automatic test_calibration();
    logic seen;
    seen      = 1'b0;
    cal_start = 1'b1;
    tick();
    cal_start = 1'b0;
    seen |= dout_valid;
    for (int i = 0; i < 4; i++) begin
      din       = 24'(i + 7);
      din_valid = 1'b1;
      tick();
      seen |= dout_valid;
    end
    din_valid = 1'b0;
    total++;
    if (calibrated !== 1'b0) begin
      bad++;
      $display("FAIL cal_wait_flag: calibrated=%0b want 0", calibrated);
    end
    load_offset(24'sd1000);
    seen |= dout_valid;
    repeat (LAT) begin
      tick();
      seen |= dout_valid;
    end
    total++;
    if (seen !== 1'b0) begin
      bad++;
      $display("FAIL cal_wait_mute: dout_valid seen=%0b want 0", seen);
    end
    sample(24'sd1500);
    total++;
    if (dout_valid !== 1'b1 || dout !== 24'sd500 || calibrated !== 1'b1) begin
      bad++;
      $display("FAIL offset_apply: v=%0b dout=%0d cal=%0b want 1/500/1", dout_valid, dout, calibrated);
    end
  endtask

  task automatic test_gain();
    load_offset(24'sd0);
    load_gain(16'd8192);
    sample(-24'sd3);
    exp_d = GAIN_EN ? -24'sd1 : -24'sd3;
    total++;
    if (dout !== exp_d || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL gain_half_neg: dout=%0d v=%0b want %0d/1", dout, dout_valid, exp_d);
    end
    sample(24'sd3);
    exp_d = GAIN_EN ? 24'sd2 : 24'sd3;
    total++;
    if (dout !== exp_d) begin
      bad++;
      $display("FAIL gain_half_pos: dout=%0d want %0d", dout, exp_d);
    end
    gain_in   = 16'd16384;
    gain_load = 1'b1;
    din       = 24'sd100;
    din_valid = 1'b1;
    tick();
    gain_load = 1'b0;
    din_valid = 1'b0;
    repeat (LAT - 1) tick();
    exp_d = GAIN_EN ? 24'sd50 : 24'sd100;
    total++;
    if (dout !== exp_d) begin
      bad++;
      $display("FAIL gain_load_coincident: dout=%0d want %0d", dout, exp_d);
    end
    sample(24'sd100);
    total++;
    if (dout !== 24'sd100) begin
      bad++;
      $display("FAIL gain_load_after: dout=%0d want 100", dout);
    end
  endtask

  task automatic test_saturation();
    load_offset(GAIN_EN ? 24'sd0 : -24'sd1);
    load_gain(16'd32768);
    sample(24'sd8388607);
    total++;
    if (dout !== 24'sd8388607 || sat_flag !== 1'b1 || sat_count !== 16'd1) begin
      bad++;
      $display("FAIL clip_pos: dout=%0d sf=%0b cnt=%0d want 8388607/1/1", dout, sat_flag, sat_count);
    end
    tick();
    total++;
    if (dout_valid !== 1'b0 || sat_flag !== 1'b0 || dout !== 24'sd8388607) begin
      bad++;
      $display("FAIL idle_hold: v=%0b sf=%0b dout=%0d want 0/0/8388607", dout_valid, sat_flag, dout);
    end
    din       = 24'sd8388607;
    din_valid = 1'b1;
    tick();
    din_valid = 1'b0;
    repeat (LAT - 2) tick();
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    total++;
    if (sat_count !== 16'd1 || sat_flag !== 1'b1 || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL clr_with_clip: cnt=%0d sf=%0b v=%0b want 1/1/1", sat_count, sat_flag, dout_valid);
    end
    sat_clr = 1'b1;
    tick();
    sat_clr = 1'b0;
    total++;
    if (sat_count !== 16'd0) begin
      bad++;
      $display("FAIL clr_alone: cnt=%0d want 0", sat_count);
    end
  endtask

  task automatic test_offset_coincident();
    load_gain(16'd16384);
    load_offset(24'sd0);
    offset_in   = 24'sd50;
    offset_load = 1'b1;
    din         = 24'sd200;
    din_valid   = 1'b1;
    tick();
    offset_load = 1'b0;
    din_valid   = 1'b0;
    repeat (LAT - 1) tick();
    total++;
    if (dout !== 24'sd200 || dout_valid !== 1'b1) begin
      bad++;
      $display("FAIL offset_coincident: dout=%0d v=%0b want 200/1", dout, dout_valid);
    end
    sample(24'sd200);
    total++;
    if (dout !== 24'sd150) begin
      bad++;
      $display("FAIL offset_after: dout=%0d want 150", dout);
    end
  endtask

  task automatic test_back_to_back();
    logic signed [23:0] d[4];
    logic               v[4];
    logic signed [23:0] last;
    int                 j;
    d = '{24'sd10, 24'sd20, 24'sd99, -24'sd30};
    v = '{1'b1, 1'b1, 1'b0, 1'b1};
    load_offset(24'sd0);
    last = 24'sd150;
    for (int i = 0; i < 4 + LAT; i++) begin
      if (i < 4) begin
        din       = d[i];
        din_valid = v[i];
      end else begin
        din_valid = 1'b0;
      end
      tick();
      j = i - (LAT - 1);
      if (j >= 0 && j < 4) begin
        if (v[j]) last = d[j];
        total++;
        if (dout_valid !== v[j] || dout !== last) begin
          bad++;
          $display("FAIL stream_%0d: v=%0b dout=%0d want %0b/%0d", j, dout_valid, dout, v[j], last);
        end
      end
    end
  endtask

  task automatic test_reset_in_flight();
    logic seen;
    load_offset(GAIN_EN ? 24'sd0 : -24'sd1);
    load_gain(16'd32768);
    sample(24'sd8388607);
    din       = 24'sd5;
    din_valid = 1'b1;
    tick();
    din = 24'sd6;
    tick();
    din   = 24'sd7;
    rst_n = 1'b0;
    #1;
    total++;
    if ({dout, dout_valid, sat_flag, sat_count, calibrated} !== '0) begin
      bad++;
      $display("FAIL reset_mid: dout=%0d v=%0b sf=%0b cnt=%0d cal=%0b want all 0",
               dout, dout_valid, sat_flag, sat_count, calibrated);
    end
    tick();
    din_valid = 1'b0;
    tick();
    rst_n = 1'b1;
    seen  = 1'b0;
    repeat (LAT + 2) begin
      tick();
      seen |= dout_valid;
    end
    total++;
    if (seen !== 1'b0 || calibrated !== 1'b0) begin
      bad++;
      $display("FAIL reset_flush: dout_valid seen=%0b cal=%0b want 0/0", seen, calibrated);
    end
    sample(24'sd100);
    total++;
    if (dout !== 24'sd100 || dout_valid !== 1'b1 || sat_flag !== 1'b0) begin
      bad++;
      $display("FAIL reset_defaults: dout=%0d v=%0b sf=%0b want 100/1/0", dout, dout_valid, sat_flag);
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    cal_start   = 1'b0;
    offset_in   = '0;
    offset_load = 1'b0;
    gain_in     = '0;
    gain_load   = 1'b0;
    din         = '0;
    din_valid   = 1'b0;
    sat_clr     = 1'b0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();
    test_reset();
    test_calibration();
    test_gain();
    test_saturation();
    test_offset_coincident();
    test_back_to_back();
    test_reset_in_flight();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/offset_gain_corr.md
OFFSET_GAIN_CORR -- requirements
Module: offset_gain_corr

Interface
REQ-001 SHALL have parameter W, default 24, sample width (signed).
REQ-002 SHALL have parameter GF, default 14, gain fractional bits; gain is unsigned Q2.GF.
REQ-003 SHALL have parameter SCW, default 16, saturation counter width.
REQ-004 SHALL have port clk  input  1  sole clock, rising edge.
REQ-005 SHALL have port rst_n  input  1  asynchronous active-low reset.
REQ-006 SHALL have port cal_start  input  1  pulse; calibration begins and output is muted.
REQ-007 SHALL have port offset_in  input  W  signed offset from the calibrator.
REQ-008 SHALL have port offset_load  input  1  pulse; capture offset_in and end calibration.
REQ-009 SHALL have port gain_in  input  GF+2  gain value; gain_load  input  1  pulse to capture it.
REQ-010 SHALL have port din  input  W  signed decimated sample; din_valid  input  1  qualifier.
REQ-011 SHALL have port dout  output  W  corrected sample; dout_valid  output  1  qualifier.
REQ-012 SHALL have port sat_flag  output  1  high with dout_valid when that sample clipped.
REQ-013 SHALL have port sat_count  output  SCW  clipped-sample count; sat_clr  input  1  pulse to clear it.
REQ-014 SHALL have port calibrated  output  1  high in state ACTIVE.

Function
REQ-015 SHALL run FSM UNCAL->CAL_WAIT on cal_start, CAL_WAIT->ACTIVE on offset_load, ACTIVE->CAL_WAIT on cal_start; offset_load in UNCAL also goes to ACTIVE.
REQ-016 SHALL suppress dout_valid for samples entering stage 1 while in CAL_WAIT; UNCAL and ACTIVE pass samples.
REQ-017 SHALL have offset_load/gain_load take effect for the first din_valid sample strictly after the load cycle; a sample coincident with the load uses the old value.
REQ-018 SHALL give cal_start and offset_load in the same cycle priority to offset_load (-> ACTIVE).
REQ-019 SHALL compute stage 1: diff = din - offset in W+1 signed bits, no overflow.
REQ-020 SHALL compute stage 2: p = diff*gain + 2^(GF-1), then arithmetic shift right by GF (round half up).
REQ-021 SHALL compute stage 3: clip to [-2^(W-1), 2^(W-1)-1], register dout, sat_flag, dout_valid.
REQ-022 SHALL have fixed latency of 3 cycles from din_valid to dout_valid, free-running, no backpressure, bubbles preserved.
REQ-023 SHALL increment sat_count on each clipped valid output, saturating at all-ones; sat_clr in the same cycle as a clip yields 1.
REQ-024 SHALL hold dout at its last value when dout_valid is low; sat_flag is 0 when dout_valid is 0.

Reset
REQ-025 SHALL, on rst_n low: FSM=UNCAL, offset=0, gain=2^GF (1.0), dout=0, dout_valid=0, sat_flag=0, sat_count=0, calibrated=0.
REQ-026 SHALL, on reset mid-operation, discard in-flight samples; no dout_valid until new input passes the full latency.

Configuration
REQ-027 SHALL use macro OFFSET_GAIN_CORR_GAIN_EN: defined -> stage 2 multiply as above, latency 3.
REQ-028 SHALL, without OFFSET_GAIN_CORR_GAIN_EN: no multiplier and no gain register; gain_in/gain_load stay as ports but are ignored; stage 2 is removed; latency 2; dout = clip(diff).

Structure
REQ-029 SHALL place FSM state encoding (UNCAL=0, CAL_WAIT=1, ACTIVE=2) and the unity-gain constant function in package offset_gain_corr_pkg.
REQ-030 SHALL implement the clip in sub-module sat_clip (parameterised input/output widths, outputs value and clip flag).

Verification (W=24, GF=14, gain feature on)
REQ-031 SHALL check: post-reset, din=100 valid -> dout=100 three cycles later, calibrated=0.
REQ-032 SHALL check: cal_start, then din valid x4 -> no dout_valid; offset_load offset_in=1000, then din=1500 -> dout=500, calibrated=1.
REQ-033 SHALL check: gain_load 8192 (0.5), din=-3 -> dout=-1; din=3 -> dout=2.
REQ-034 SHALL check: gain 32768 (2.0), din=8388607 -> dout=8388607, sat_flag=1, sat_count=1; sat_clr plus simultaneous clip -> sat_count=1.
REQ-035 SHALL check: offset_load offset_in=50 coincident with din=200 valid -> dout=200; the next sample din=200 -> dout=150.
REQ-036 SHALL check: rst_n pulsed with 3 samples in flight -> dout_valid stays 0 and all outputs return to reset values.
